// File: rtl/cla_sub_25bit_pipe_pkg.sv
// Shared arithmetic package for the pipelined CLA subtractor.
// Holds the default operand width and the stage-1/stage-2 split point,
// plus the layout of the record carried from stage 1 into stage 2.
package cla_sub_25bit_pipe_pkg;

  localparam int unsigned CLA_WIDTH = 25;
  localparam int unsigned CLA_SPLIT = 16;
  localparam int unsigned CLA_HI    = CLA_WIDTH - CLA_SPLIT;

  // Stage-1 register record: the resolved low difference, the carry into
  // the upper slice, the untouched upper operands (B already inverted),
  // and whether the low difference is all zero.
  typedef struct packed {
    logic [CLA_HI-1:0]    a_hi;
    logic [CLA_HI-1:0]    nb_hi;
    logic                 c_mid;
    logic                 lo_zero;
    logic [CLA_SPLIT-1:0] d_lo;
  } s1_rec_t;

endpackage

// File: rtl/cla_sub_25bit_pipe_add_stage.sv
// cla_add_stage: N-bit carry-lookahead adder slice.
// Ports:
//   a, b   - N-bit addends
//   cin    - carry in
//   s      - N-bit sum
//   cout   - carry out
//   p_grp  - group propagate (all bits propagate)
//   g_grp  - group generate (carry out assuming cin = 0)
module cla_add_stage #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         p_grp,
  output logic         g_grp
);

  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   c;
  logic         gterm;
  logic         pprod;

  // Each carry is built as a flat sum of products over the lower bits
  // (g[j] & p[j+1..i]) plus cin & p[0..i], rather than chaining c[i].
  always_comb begin
    p     = a ^ b;
    g     = a & b;
    c     = '0;
    c[0]  = cin;
    g_grp = 1'b0;
    gterm = 1'b0;
    pprod = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      gterm = g[i];
      pprod = p[i];
      for (int unsigned k = 0; k < i; k++) begin
        gterm = gterm | (pprod & g[i-1-k]);
        pprod = pprod & p[i-1-k];
      end
      c[i+1] = gterm | (pprod & cin);
      if (i == N - 1) begin
        g_grp = gterm;
      end
    end
    p_grp = &p;
    s     = p ^ c[N-1:0];
    cout  = c[N];
  end

endmodule

// File: rtl/cla_sub_25bit_pipe.sv
// cla_sub_25bit_pipe: two-stage pipelined unsigned subtractor,
// D = A - B - bin computed as A + ~B + ~bin with CLA slices.
// Stage 1 resolves bits [SPLIT:1]; stage 2 resolves [WIDTH:SPLIT+1].
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (A, B, bin)
//   out_valid/out_ready - result handshake (D, bout, zero)
//   bout                - 1 when A < B + bin
//   zero                - 1 when D == 0
module cla_sub_25bit_pipe
  import cla_sub_25bit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned SPLIT = CLA_SPLIT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:1] A,
  input  logic [WIDTH:1] B,
  input  logic           bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:1] D,
  output logic           bout,
  output logic           zero
);

  // The stage record is laid out from the package defaults, so the
  // parameters must agree with them.
  if (WIDTH != CLA_WIDTH || SPLIT != CLA_SPLIT) begin : g_param_check
    $error("cla_sub_25bit_pipe: WIDTH/SPLIT must match the package record");
  end

  localparam int unsigned HI = WIDTH - SPLIT;

  logic             s1_valid_q, s1_valid_d;
  s1_rec_t          s1_q, s1_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic             s1_load;
  logic             s2_load;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic             lo_p_unused;
  logic             lo_g_unused;

  logic [HI-1:0]    hi_sum;
  logic             hi_cout_unused;
  logic             hi_p;
  logic             hi_g;
  logic             c_final;

  // Stage 1: low slice, subtraction as A + ~B with carry-in ~bin.
  cla_add_stage #(.N(SPLIT)) u_stage1 (
    .a     (A[SPLIT:1]),
    .b     (~B[SPLIT:1]),
    .cin   (~bin),
    .s     (lo_sum),
    .cout  (lo_cout),
    .p_grp (lo_p_unused),
    .g_grp (lo_g_unused)
  );

  // Stage 2: high slice from the registered operands and carry.
  cla_add_stage #(.N(HI)) u_stage2 (
    .a     (s1_q.a_hi),
    .b     (s1_q.nb_hi),
    .cin   (s1_q.c_mid),
    .s     (hi_sum),
    .cout  (hi_cout_unused),
    .p_grp (hi_p),
    .g_grp (hi_g)
  );

  // Final carry from the high group's lookahead terms; no carry means borrow.
  assign c_final = hi_g | (hi_p & s1_q.c_mid);

  assign in_ready  = ~s1_valid_q | ~out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign bout      = bout_q;
  assign zero      = zero_q;

  always_comb begin
    s1_load = in_valid & in_ready;
    s2_load = s1_valid_q & (~out_valid_q | out_ready);

    s1_valid_d = s1_valid_q;
    if (s2_load) s1_valid_d = 1'b0;
    if (s1_load) s1_valid_d = 1'b1;

    s1_d = s1_q;
    if (s1_load) begin
      s1_d.a_hi    = A[WIDTH:SPLIT+1];
      s1_d.nb_hi   = ~B[WIDTH:SPLIT+1];
      s1_d.c_mid   = lo_cout;
      s1_d.lo_zero = (lo_sum == '0);
      s1_d.d_lo    = lo_sum;
    end

    out_valid_d = out_valid_q;
    if (out_ready) out_valid_d = 1'b0;
    if (s2_load)   out_valid_d = 1'b1;

    d_d    = d_q;
    bout_d = bout_q;
    zero_d = zero_q;
    if (s2_load) begin
      d_d    = {hi_sum, s1_q.d_lo};
      bout_d = ~c_final;
      zero_d = s1_q.lo_zero & (hi_sum == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_cla_sub_25bit_pipe.sv
// Bench for cla_sub_25bit_pipe: directed steps driving a scoreboard queue
// of expected results, popped when the DUT transfers a result.
module tb_cla_sub_25bit_pipe;

  localparam int unsigned W = 25;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W:1]   A;
  logic [W:1]   B;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W:1]   D;
  logic         bout;
  logic         zero;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         zero;
  } exp_t;

  exp_t         sb[$];
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  bit           hold_pend = 1'b0;
  logic [W-1:0] hold_d;
  logic         hold_b;
  logic         hold_z;

  always #5 clk = ~clk;

  cla_sub_25bit_pipe #(.WIDTH(25), .SPLIT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .bout      (bout),
    .zero      (zero)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi);
    exp_t     r;
    logic [W:0] t;
    t      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    r.d    = t[W-1:0];
    r.bout = t[W];
    r.zero = (t[W-1:0] == '0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample handshakes at the falling edge, score any
  // transfer, then return just after the rising edge.
  task automatic tick(output bit acc, output bit ov);
    exp_t e;
    @(negedge clk);
    ov  = (out_valid === 1'b1);
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    if (hold_pend && out_valid === 1'b1) begin
      chk("hold_D", 32'(D), 32'(hold_d));
      chk("hold_bout", 32'(bout), 32'(hold_b));
      chk("hold_zero", 32'(zero), 32'(hold_z));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("sb_nonempty_at_out", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_D", 32'(D), 32'(e.d));
        chk("sb_bout", 32'(bout), 32'(e.bout));
        chk("sb_zero", 32'(zero), 32'(e.zero));
      end
    end
    hold_pend = (out_valid === 1'b1) && (out_ready === 1'b0);
    hold_d    = D;
    hold_b    = bout;
    hold_z    = zero;
    if (acc) sb.push_back(model(A, B, bin));
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] ed, input logic eb, input logic ez);
    bit acc, ov;
    A = a; B = b; bin = bi; in_valid = 1'b1;
    tick(acc, ov);
    chk("single_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    tick(acc, ov);
    chk("latency_after_accept_edge", 32'(ov), 32'd0);
    tick(acc, ov);
    chk("latency_second_edge", 32'(ov), 32'd1);
    chk("single_D", 32'(D), 32'(ed));
    chk("single_bout", 32'(bout), 32'(eb));
    chk("single_zero", 32'(zero), 32'(ez));
    chk("single_sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sa[4];
    logic [W-1:0] sbv[4];
    int unsigned  idx;
    int unsigned  budget;
    bit           acc, ov;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed points, including the borrow across the split and equality.
    single(25'h0000010, 25'h0000001, 1'b0, 25'h000000F, 1'b0, 1'b0);
    single(25'h0000000, 25'h0000001, 1'b0, 25'h1FFFFFF, 1'b1, 1'b0);
    single(25'h0010000, 25'h0000000, 1'b1, 25'h000FFFF, 1'b0, 1'b0);
    single(25'h1ABCDEF, 25'h1ABCDEF, 1'b0, 25'h0000000, 1'b0, 1'b1);
    single(25'h1ABCDEF, 25'h1ABCDEF, 1'b1, 25'h1FFFFFF, 1'b1, 1'b0);
    single(25'h1FFFFFF, 25'h0000000, 1'b0, 25'h1FFFFFF, 1'b0, 1'b0);

    // Stall: four back-to-back beats against a blocked consumer.
    sa[0] = 25'h0123456; sbv[0] = 25'h0012345;
    sa[1] = 25'h0000001; sbv[1] = 25'h0000002;
    sa[2] = 25'h1000000; sbv[2] = 25'h0FFFFFF;
    sa[3] = 25'h00F0F0F; sbv[3] = 25'h00F0F0F;
    out_ready = 1'b0; idx = 0; bin = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) begin A = sa[idx]; B = sbv[idx]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick(acc, ov);
      if (acc) idx++;
    end
    chk("stall_accepted", idx, 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (idx < 4) begin A = sa[idx]; B = sbv[idx]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick(acc, ov);
      chk("drain_one_per_cycle", 32'(ov), 32'd1);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("stall_all_accepted", idx, 32'd4);
    chk("stall_sb_empty", sb.size(), 32'd0);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 80; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       A = '0;
        1:       A = '1;
        default: A = W'($urandom);
      endcase
      B   = ($urandom_range(0, 4) == 0) ? A : W'($urandom);
      bin = 1'($urandom_range(0, 1));
      tick(acc, ov);
    end
    in_valid = 1'b0; out_ready = 1'b1; budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      tick(acc, ov);
      budget++;
    end
    chk("random_drain", sb.size(), 32'd0);

    // Reset with a result waiting and another beat in stage 1.
    out_ready = 1'b0; bin = 1'b0;
    A = 25'h0000005; B = 25'h0000003; in_valid = 1'b1;
    tick(acc, ov);
    A = 25'h0000007;
    tick(acc, ov);
    in_valid = 1'b0;
    tick(acc, ov);
    chk("pre_reset_out_valid", 32'(ov), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_D", 32'(D), 32'd0);
    chk("async_rst_bout", 32'(bout), 32'd0);
    sb.delete();
    hold_pend = 1'b0;
    tick(acc, ov);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(acc, ov);
      chk("no_stale_after_reset", 32'(ov), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
